crossbar_rr_sched: RTL and testbench

//  Round-robin scheduler and registered output stage for the N-to-M compacting crossbar.
//  - Each advancing cycle it grants up to M of the N requesters and places their data on M output slots.
//  - A rotating priority pointer guarantees fairness when more than M requesters are active.
//  - Output slots are registered and advance as a group under a single oready backpressure signal.

---
 rtl/crossbar_rr_sched.sv | 108 ++++++++++
 tb/tb_crossbar_rr_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_rr_sched
// Description : Round-robin grant of up to M of N requesters per advancing
//               cycle, compacted into M registered output slots.
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_rr_sched #(
    parameter  int DATA_W = 16,
    parameter  int N      = 6,
    parameter  int M      = 4,
    localparam int ID_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      ireq,
    input  logic [DATA_W-1:0] idata  [N],
    output logic [N-1:0]      igrant,
    output logic [M-1:0]      oreq,
    output logic [DATA_W-1:0] odata  [M],
    output logic [ID_W-1:0]   osrc   [M],
    input  logic              oready
);

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    logic [ID_W-1:0]   r_ptr;
    logic [M-1:0]      r_vld;
    logic [DATA_W-1:0] r_dat [M];
    logic [ID_W-1:0]   r_src [M];

    logic              w_adv;
    logic              w_any;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_last;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [N-1:0]      w_grant;
    logic [M-1:0]      w_vld;
    logic [ID_W-1:0]   w_src [M];
    logic [DATA_W-1:0] w_dat [M];
    int                w_cnt;

    // Gating with rst_n keeps igrant low for the whole time reset is held.
    assign w_adv = rst_n & ((r_vld == '0) | oready);

    // Scan from r_ptr with explicit wrap; k-th grant fills slot k.
    always_comb begin
        w_grant = '0;
        w_vld   = '0;
        w_any   = 1'b0;
        w_cnt   = 0;
        w_last  = r_ptr;
        w_idx   = r_ptr;
        for (int s = 0; s < M; s++) begin
            w_src[s] = '0;
        end
        for (int k = 0; k < N; k++) begin
            if (w_adv && ireq[w_idx] && (w_cnt < M)) begin
                w_grant[w_idx] = 1'b1;
                for (int s = 0; s < M; s++) begin
                    if (s == w_cnt) begin
                        w_vld[s] = 1'b1;
                        w_src[s] = w_idx;
                    end
                end
                w_last = w_idx;
                w_any  = 1'b1;
                w_cnt  = w_cnt + 1;
            end
            w_idx = next_idx(w_idx);
        end
        w_ptr_nxt = w_any ? next_idx(w_last) : r_ptr;
    end

    // idata only reaches the slot registers, never an output directly.
    always_comb begin
        for (int s = 0; s < M; s++) begin
            w_dat[s] = w_vld[s] ? idata[w_src[s]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_vld <= '0;
            for (int s = 0; s < M; s++) begin
                r_dat[s] <= '0;
                r_src[s] <= '0;
            end
        end else if (w_adv) begin
            r_ptr <= w_ptr_nxt;
            r_vld <= w_vld;
            for (int s = 0; s < M; s++) begin
                r_dat[s] <= w_dat[s];
                r_src[s] <= w_src[s];
            end
        end
    end

    assign igrant = w_grant;
    assign oreq   = r_vld;
    assign odata  = r_dat;
    assign osrc   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_crossbar_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_crossbar_rr_sched
// Description : Scoreboard bench for crossbar_rr_sched (N=6, M=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crossbar_rr_sched;
    localparam int DATA_W = 16;
    localparam int N      = 6;
    localparam int M      = 4;
    localparam int ID_W   = 3;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic [N-1:0]      ireq   = '0;
    logic              oready = 1'b0;
    logic [DATA_W-1:0] idata  [N];
    logic [N-1:0]      igrant;
    logic [M-1:0]      oreq;
    logic [DATA_W-1:0] odata  [M];
    logic [ID_W-1:0]   osrc   [M];

    always #5 clk = ~clk;

    crossbar_rr_sched #(.DATA_W(DATA_W), .N(N), .M(M)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ireq   (ireq),
        .idata  (idata),
        .igrant (igrant),
        .oreq   (oreq),
        .odata  (odata),
        .osrc   (osrc),
        .oready (oready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state and scoreboard queues
    logic [ID_W-1:0]        m_ptr;
    logic [M-1:0]           m_vld;
    logic [DATA_W*M-1:0]    m_dat;
    logic [ID_W*M-1:0]      m_src;
    logic [N-1:0]           m_grant;
    logic [N-1:0]           g_seen;
    logic                   fair_on = 1'b0;
    int                     wait_cnt [N];
    logic [M-1:0]           q_v [$];
    logic [DATA_W*M-1:0]    q_d [$];
    logic [ID_W*M-1:0]      q_s [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W*M-1:0] flat_d();
        logic [DATA_W*M-1:0] f;
        for (int s = 0; s < M; s++) f[s*DATA_W +: DATA_W] = odata[s];
        return f;
    endfunction

    function automatic logic [ID_W*M-1:0] flat_s();
        logic [ID_W*M-1:0] f;
        for (int s = 0; s < M; s++) f[s*ID_W +: ID_W] = osrc[s];
        return f;
    endfunction

    task automatic model_reset();
        m_ptr   = '0;
        m_vld   = '0;
        m_dat   = '0;
        m_src   = '0;
        m_grant = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // Drive one cycle at the falling edge, predict, then compare after the rising edge.
    task automatic step(input logic [N-1:0] req, input logic rdy);
        logic                adv;
        int                  n;
        int                  p;
        logic [M-1:0]        ev;
        logic [DATA_W*M-1:0] ed;
        logic [ID_W*M-1:0]   es;
        ireq   = req;
        oready = rdy;
        #1;
        adv     = (m_vld == '0) | rdy;
        m_grant = '0;
        n  = 0;
        p  = int'(m_ptr);
        ev = '0;
        ed = '0;
        es = '0;
        for (int k = 0; k < N; k++) begin
            if (adv && req[p] && n < M) begin
                m_grant[p]                = 1'b1;
                ev[n]                     = 1'b1;
                ed[n*DATA_W +: DATA_W]    = idata[p];
                es[n*ID_W +: ID_W]        = ID_W'(p);
                m_ptr                     = ID_W'((p + 1) % N);
                n++;
            end
            p = (p + 1) % N;
        end
        g_seen = igrant;
        chk("igrant", igrant, m_grant);
        if (fair_on && adv) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_grant[i]) begin
                        chk("fair_wait", wait_cnt[i] <= 1, 1'b1);
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                    end
                end
            end
        end
        if (adv) begin
            m_vld = ev;
            m_dat = ed;
            m_src = es;
        end
        q_v.push_back(m_vld);
        q_d.push_back(m_dat);
        q_s.push_back(m_src);
        @(posedge clk);
        @(negedge clk);
        chk("oreq",  oreq,     q_v.pop_front());
        chk("odata", flat_d(), q_d.pop_front());
        chk("osrc",  flat_s(), q_s.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] cur;
        for (int i = 0; i < N; i++) idata[i] = DATA_W'($urandom);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_oreq",   oreq,   4'b0000);
        chk("rst_igrant", igrant, 6'b000000);
        rst_n = 1'b1;

        // T1: reset while the stage is full
        step(6'b111111, 1'b1);
        chk("t1_full", oreq, 4'b1111);
        rst_n = 1'b0;
        #1;
        chk("t1_oreq",   oreq,     4'b0000);
        chk("t1_odata",  flat_d(), 64'h0);
        chk("t1_osrc",   flat_s(), 12'h0);
        chk("t1_igrant", igrant,   6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // T2: everyone requesting from ptr=0
        step(6'b111111, 1'b1);
        chk("t2_g0",   g_seen,   6'b001111);
        chk("t2_src0", flat_s(), {3'd3, 3'd2, 3'd1, 3'd0});
        step(6'b111111, 1'b1);
        chk("t2_g1",   g_seen,   6'b110011);
        chk("t2_src1", flat_s(), {3'd1, 3'd0, 3'd5, 3'd4});
        step(6'b111111, 1'b1);
        chk("t2_g2",   g_seen,   6'b111100);

        // T3: sparse requests, pointer wraps to 0
        idata[2] = 16'hAAAA;
        idata[5] = 16'h5555;
        step(6'b100100, 1'b1);
        chk("t3_g",     g_seen,   6'b100100);
        chk("t3_oreq",  oreq,     4'b0011);
        chk("t3_d0",    odata[0], 16'hAAAA);
        chk("t3_s0",    osrc[0],  3'd2);
        chk("t3_d1",    odata[1], 16'h5555);
        chk("t3_s1",    osrc[1],  3'd5);
        step(6'b111111, 1'b1);
        chk("t3_wrap",  g_seen,   6'b001111);

        // T4: backpressure on a full stage
        for (int c = 0; c < 3; c++) begin
            step(6'b111111, 1'b0);
            chk("t4_hold_g", g_seen, 6'b000000);
        end
        step(6'b111111, 1'b1);
        chk("t4_resume", g_seen, 6'b110011);

        // T5: idle, then an empty stage loads despite oready=0
        step(6'b000000, 1'b1);
        chk("t5_empty", oreq, 4'b0000);
        step(6'b000001, 1'b0);
        chk("t5_g", g_seen, 6'b000001);
        step(6'b111111, 1'b1);
        chk("t5_ptr", g_seen, 6'b011110);

        // T6: random traffic; requests held until granted
        fair_on = 1'b1;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        cur = ireq;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(cur[i] && !m_grant[i])) begin
                    cur[i]   = ($urandom_range(0, 2) != 0);
                    idata[i] = DATA_W'($urandom);
                end
            end
            step(cur, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
